node_mac_seq: RTL and testbench
===============================

# node_mac_seq

Parametrised, time-multiplexed fully-connected neuron for the ECG network layers. It accepts a vector of N_IN signed activations together with weights and bias over a valid/ready handshake, then accumulates one product per cycle into a widened accumulator. It then rounds, right-shifts by FRAC, saturates, optionally applies ReLU, and presents one DW-bit activation on a valid/ready output. It replaces the fixed ten-input, fully parallel layer nodes, trading multiplier count for latency, and drops into layer generators for any fan-in.

## Interface
- N_IN, default 10: number of inputs (≥1).
- DW, default 8: activation/weight width, two's complement.
- FRAC, default 6: fraction bits removed after accumulation, range 1..2*DW-1.
- Derived, not overridable: PW = 2*DW (product and bias width); ACC_W = PW + $clog2(N_IN) + 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a_flat  in  N_IN*DW  activations; element i at [i*DW +: DW].
- w_flat  in  N_IN*DW  weights, same packing.
- bias  in  PW  bias, same scale as a product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- n_out  out  DW  neuron output.

## Operation
- FSM states: IDLE, MAC, ROUND, HOLD.
- **IDLE:** in_ready=1. When in_valid&&in_ready, register a_flat, w_flat into local copies; acc ← sign-extended bias; idx ← 0; go to MAC.
- **MAC:** acc ← acc + sext(a[idx]*w[idx]), signed DW×DW→PW. idx increments. After idx==N_IN-1, go to ROUND. This takes exactly N_IN cycles.
- **ROUND:**
  - r = (acc + 2^(FRAC-1)) >>> FRAC. This is an arithmetic shift giving round-half-up; the add is done at ACC_W+1 bits with no wrap.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - Register the result into n_out, set out_valid=1, go to HOLD.
- **HOLD:** n_out and out_valid are stable until out_ready=1. On that edge, out_valid ← 0 and the FSM goes to IDLE.
- Saturation is applied after rounding. A rounded value of 2^(DW-1) clamps to 2^(DW-1)-1 and never wraps.
- in_valid outside IDLE is ignored, and inputs are not sampled. The input side keeps its data until in_ready.
- **Reset, at any time including mid-MAC or HOLD:**
  - The state returns to IDLE.
  - n_out=0, out_valid=0, acc=0, idx=0, local operand copies=0.
  - in_ready=1 from the first cycle after reset deasserts.

## Timing
- Accept edge is T0.
- MAC edges are T1..T(N_IN).
- ROUND edge is T(N_IN+1). out_valid is high after it, so latency is N_IN+1 cycles from accept to out_valid.
- With out_ready held high, the out handshake completes at T(N_IN+2). in_ready is high in the following cycle.
- Throughput is one vector per N_IN+3 cycles.
- in_ready is a registered state decode with no combinational path from out_ready.

## Configuration
- NODE_RELU_EN defined: after rounding, negative r gives n_out=0, so the output range is [0, 2^(DW-1)-1]. This matches hidden-layer behaviour.
- NODE_RELU_EN undefined: symmetric signed saturation, output range [-2^(DW-1), 2^(DW-1)-1]. Used for output-layer logits.

## Structure
- Shared package node_pkg holds:
  - the FSM state enum (node_state_t),
  - the function acc_width(n_in, dw),
  - the rounding/saturation constants shared with other layer blocks.
- One sub-module, node_round_sat: combinational round, shift, saturate, and ReLU (under NODE_RELU_EN). Parameters are ACC_W, DW, FRAC. It is reused by other layer nodes.

## Test plan
All scenarios use N_IN=10, DW=8, FRAC=6, bias 0 unless stated.
- Single term: a0=64, w0=64, rest 0 → n_out=64. out_valid is high exactly 11 cycles after the accept edge.
- Rounding boundary: a0=1, w0=32 → n_out=1. a0=1, w0=31 → n_out=0.
- Sign:
  - a0=64, w0=-64 → n_out=-64 (8'hC0) without NODE_RELU_EN.
  - Same input → n_out=0 with NODE_RELU_EN.
- Saturation:
  - All a=64, w=64 → n_out=127.
  - bias=8160 with all products 0 → rounds to 128 → n_out=127, not -128.
  - Without NODE_RELU_EN, all a=64, w=-64 → n_out=-128.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises → n_out and out_valid stay stable and in_ready stays 0. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-MAC: assert reset at T4 → next cycle out_valid=0, n_out=0, in_ready=1. A new vector then produces the correct result with no residue from the aborted one.

Source files
------------

// File: rtl/node_pkg.sv
// Shared types and width helpers for the time-multiplexed layer nodes.
// The NODE_RELU_EN build option is consumed by node_round_sat.
package node_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND,
      HOLD
   } node_state_t;

   // One extra bit above the accumulator so the rounding add never wraps.
   localparam int RND_EXT_BITS = 1;

   function automatic int acc_width(input int n_in, input int dw);
      return 2 * dw + $clog2(n_in) + 1;
   endfunction

   function automatic int idx_width(input int n_in);
      return (n_in > 1) ? $clog2(n_in) : 1;
   endfunction

endpackage

// File: rtl/node_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and saturation to DW bits.
// With NODE_RELU_EN defined, negative results are forced to zero.
module node_round_sat
   import node_pkg::*;
#(
   parameter int ACC_W = 21,
   parameter int DW    = 8,
   parameter int FRAC  = 6
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [DW-1:0]    res
);

   localparam int RW = ACC_W + RND_EXT_BITS;

   localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [RW-1:0] HI   = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [RW-1:0] LO   = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [RW-1:0] w;
      w = {a[ACC_W-1], a};
      w = w + HALF;
      return w >>> FRAC;
   endfunction

   function automatic logic signed [DW-1:0] saturate(input logic signed [RW-1:0] r);
`ifdef NODE_RELU_EN
      if (r < 0)
         return '0;
`endif
      if (r > HI)
         return HI[DW-1:0];
      else if (r < LO)
         return LO[DW-1:0];
      else
         return r[DW-1:0];
   endfunction

   assign res = saturate(round_shift(acc));

endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed fully-connected neuron: one signed product per cycle into a
// widened accumulator, then round/shift/saturate (ReLU when NODE_RELU_EN is defined).
module node_mac_seq
   import node_pkg::*;
#(
   parameter int N_IN = 10,
   parameter int DW   = 8,
   parameter int FRAC = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN*DW-1:0]   a_flat,
   input  logic [N_IN*DW-1:0]   w_flat,
   input  logic [2*DW-1:0]      bias,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] n_out
);

   localparam int PW    = 2 * DW;
   localparam int ACC_W = acc_width(N_IN, DW);
   localparam int IDX_W = idx_width(N_IN);

   node_state_t state, state_nx;

   logic [N_IN*DW-1:0]      a_loc, w_loc;
   logic signed [ACC_W-1:0] acc;
   logic [IDX_W-1:0]        idx;
   logic signed [DW-1:0]    a_sel, w_sel, res;
   logic signed [PW-1:0]    prod;
   logic                    last;

   assign a_sel    = a_loc[idx*DW +: DW];
   assign w_sel    = w_loc[idx*DW +: DW];
   assign prod     = a_sel * w_sel;
   assign last     = (idx == IDX_W'(N_IN - 1));
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = MAC;
         MAC:     if (last)      state_nx = ROUND;
         ROUND:                  state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Operand capture, accumulate, and output register; all cleared by reset
   // so an aborted vector leaves no residue.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_loc     <= '0;
         w_loc     <= '0;
         acc       <= '0;
         idx       <= '0;
         n_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_loc <= a_flat;
                  w_loc <= w_flat;
                  acc   <= {{(ACC_W-PW){bias[PW-1]}}, bias};
                  idx   <= '0;
               end
            end
            MAC: begin
               acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
               idx <= last ? '0 : idx + 1'b1;
            end
            ROUND: begin
               n_out     <= res;
               out_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   node_round_sat #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .FRAC  (FRAC)
   ) u_round_sat (
      .acc (acc),
      .res (res)
   );

endmodule

// File: tb/tb_node_mac_seq.sv
// Scoreboard bench for node_mac_seq (N_IN=10, DW=8, FRAC=6); expectations follow
// the NODE_RELU_EN setting of the build.
module tb_node_mac_seq;

   localparam int N_IN = 10;
   localparam int DW   = 8;
   localparam int FRAC = 6;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [N_IN*DW-1:0]   a_flat;
   logic [N_IN*DW-1:0]   w_flat;
   logic [2*DW-1:0]      bias;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] n_out;

   node_mac_seq #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_flat    (a_flat),
      .w_flat    (w_flat),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .n_out     (n_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [DW-1:0] av [N_IN];
   logic signed [DW-1:0] wv [N_IN];
   logic signed [DW-1:0] sb [$];
   int                   accept_cyc;

   function automatic logic signed [DW-1:0] model(input logic signed [2*DW-1:0] b);
      longint s, r;
      s = b;
      for (int i = 0; i < N_IN; i++) s += longint'(av[i]) * longint'(wv[i]);
      r = (s + 32) >>> FRAC;
`ifdef NODE_RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return 8'(r);
   endfunction

   task automatic clear_vec();
      for (int i = 0; i < N_IN; i++) begin
         av[i] = '0;
         wv[i] = '0;
      end
   endtask

   // Push the model result, then offer the vector until it is accepted.
   task automatic send(input logic signed [2*DW-1:0] b);
      int waited = 0;
      sb.push_back(model(b));
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      for (int i = 0; i < N_IN; i++) begin
         a_flat[i*DW +: DW] = av[i];
         w_flat[i*DW +: DW] = wv[i];
      end
      bias     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      accept_cyc = cyc;
      in_valid   = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_flat = '0; w_flat = '0; bias = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || n_out !== 8'sd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: out_valid=%0b n_out=%0d in_ready=%0b required 0/0/1",
                  out_valid, n_out, in_ready);
      end
   endtask

   task automatic test_single_term();
      int lat;
      logic signed [DW-1:0] exp;
      clear_vec(); av[0] = 64; wv[0] = 64;
      send(16'sd0);
      wait_out(lat);
      n_checks++;
      if (lat !== 11) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles required 11", lat);
      end
      exp = sb.pop_front();
      n_checks++;
      if (n_out !== exp || exp !== 8'sd64) begin
         n_fail++;
         $display("FAIL single_value: n_out=%0d required %0d", n_out, exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_handshake: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
   endtask

   // Runs one vector with immediate consumption and compares against the scoreboard.
   task automatic test_vectors(input string name, input logic signed [2*DW-1:0] b,
                               input logic signed [DW-1:0] want);
      int lat;
      logic signed [DW-1:0] exp;
      send(b);
      wait_out(lat);
      exp = sb.pop_front();
      n_checks++;
      if (lat < 0 || n_out !== exp || exp !== want) begin
         n_fail++;
         $display("FAIL %s: n_out=%0d lat=%0d required %0d", name, n_out, lat, want);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_rounding();
      clear_vec(); av[0] = 1; wv[0] = 32;
      test_vectors("round_up", 16'sd0, 8'sd1);
      clear_vec(); av[0] = 1; wv[0] = 31;
      test_vectors("round_down", 16'sd0, 8'sd0);
   endtask

   task automatic test_sign();
      clear_vec(); av[0] = 64; wv[0] = -64;
`ifdef NODE_RELU_EN
      test_vectors("sign_relu", 16'sd0, 8'sd0);
`else
      test_vectors("sign_neg", 16'sd0, -8'sd64);
`endif
   endtask

   task automatic test_saturation();
      for (int i = 0; i < N_IN; i++) begin av[i] = 64; wv[i] = 64; end
      test_vectors("sat_pos", 16'sd0, 8'sd127);
      clear_vec();
      test_vectors("sat_bias_128", 16'sd8160, 8'sd127);
      for (int i = 0; i < N_IN; i++) begin av[i] = 64; wv[i] = -64; end
`ifdef NODE_RELU_EN
      test_vectors("sat_neg_relu", 16'sd0, 8'sd0);
`else
      test_vectors("sat_neg", 16'sd0, -8'sd128);
`endif
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      logic signed [DW-1:0] exp;
      clear_vec(); av[3] = 50; wv[3] = 40; av[7] = -20; wv[7] = 9;
      send(16'sd100);
      wait_out(lat);
      exp = sb.pop_front();
      n_checks++;
      if (lat !== 11 || n_out !== exp) begin
         n_fail++;
         $display("FAIL bp_first: n_out=%0d lat=%0d required %0d/11", n_out, lat, exp);
      end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || n_out !== exp || in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles required 0 (n_out=%0d exp=%0d)", bad, n_out, exp);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_mac();
      logic signed [DW-1:0] dropped;
      for (int i = 0; i < N_IN; i++) begin av[i] = 64; wv[i] = 64; end
      send(16'sd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      dropped = sb.pop_back();
      n_checks++;
      if (out_valid !== 1'b0 || n_out !== 8'sd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_mac: out_valid=%0b n_out=%0d in_ready=%0b required 0/0/1 (dropped %0d)",
                  out_valid, n_out, in_ready, dropped);
      end
      clear_vec(); av[9] = 10; wv[9] = 20;
      test_vectors("after_reset", 16'sd0, 8'sd3);
   endtask

   task automatic test_back_to_back();
      int lat;
      int prev_accept;
      logic signed [DW-1:0] exp;
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < N_IN; i++) begin
            av[i] = 8'($urandom_range(0, 255));
            wv[i] = 8'($urandom_range(0, 255));
         end
         prev_accept = accept_cyc;
         send(16'($urandom_range(0, 65535)));
         if (v > 0) begin
            n_checks++;
            if (accept_cyc - prev_accept != N_IN + 3) begin
               n_fail++;
               $display("FAIL b2b_period: %0d cycles required %0d", accept_cyc - prev_accept, N_IN + 3);
            end
         end
         wait_out(lat);
         exp = sb.pop_front();
         n_checks++;
         if (lat !== 11 || n_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_value%0d: n_out=%0d lat=%0d required %0d/11", v, n_out, lat, exp);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      in_valid = 1'b0;
      out_ready = 1'b0;
      accept_cyc = 0;
      test_reset();
      test_single_term();
      test_rounding();
      test_sign();
      test_saturation();
      test_backpressure();
      test_reset_mid_mac();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
